// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and sizing helpers for the digit-serial adder/accumulator.
//   - state_t  : controller states (IDLE, RUN, DONE)
//   - ndig_f   : number of digit cycles per operation, NDIG = WIDTH/DIGIT
//   - cnt_w_f  : digit counter width, $clog2(NDIG+1)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int DIGIT_DEF = 1;

  // NDIG = WIDTH/DIGIT
  function automatic int ndig_f(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_w_f(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/serial_adder_acc_digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
//   Combinational DIGIT-bit ripple-carry slice built from half-adder pairs.
//   Ports:
//     a_d, b_d  in  [DIGIT-1:0]  operand digits
//     cin       in  1            carry into bit 0
//     s_d       out [DIGIT-1:0]  sum digit
//     cout      out 1            carry out of bit DIGIT-1
// -----------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    logic p;   // first half adder: propagate
    logic g;   // first half adder: generate
    logic q;   // second half adder: carry from propagate + incoming carry
    assign p        = a_d[i] ^ b_d[i];
    assign g        = a_d[i] & b_d[i];
    assign s_d[i]   = p ^ c[i];
    assign q        = p & c[i];
    assign c[i + 1] = g | q;
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/serial_adder_acc.sv
// -----------------------------------------------------------------------------
// serial_adder_acc
//   Digit-serial WIDTH-bit adder, DIGIT bits per clock, with valid/ready
//   handshakes and an optional internal accumulator (B := accumulator).
//   Optional feature macro: SERIAL_ADDER_SUB_EN enables A-B via the sub input;
//   without it sub is ignored and the block always adds.
//   Ports:
//     clk, rst_n          clock / asynchronous active-low reset
//     in_valid, in_ready  input handshake (accept only in IDLE)
//     a, b                operands (b ignored when acc_mode=1)
//     acc_mode            use accumulator as B and write the result back
//     acc_clr             clear accumulator (IDLE only; wins over acc_mode)
//     sub                 subtract (SERIAL_ADDER_SUB_EN builds only)
//     out_valid, out_ready output handshake (held in DONE)
//     sum, cout           last completed result and its MSB carry
// -----------------------------------------------------------------------------
module serial_adder_acc
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_mode,
  input  logic             acc_clr,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NDIG  = ndig_f(WIDTH, DIGIT);
  localparam int CNT_W = cnt_w_f(WIDTH, DIGIT);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("serial_adder_acc: WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
  end

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_sh, b_sh, res_sh, res_nx, acc, sum_q;
  logic [WIDTH-1:0]   b_src;
  logic [CNT_W-1:0]   cnt;
  logic               carry, cout_q, acc_op, sub_eff;
  logic               accept, last;
  logic [DIGIT-1:0]   s_d;
  logic               c_d;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
`endif

  assign accept    = in_valid && (state == IDLE);
  assign last      = (cnt == CNT_W'(NDIG - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Clear wins over accumulate: a coincident clear feeds B = 0.
  assign b_src = acc_mode ? (acc_clr ? '0 : acc) : b;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_d  (a_sh[DIGIT-1:0]),
    .b_d  (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .s_d  (s_d),
    .cout (c_d)
  );

  // New digit enters at the MSB end; after NDIG shifts the LSB digit is at the bottom.
  assign res_nx = (res_sh >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      acc    <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      acc_op <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (acc_clr) acc <= '0;
          if (accept) begin
            a_sh   <= a;
            b_sh   <= sub_eff ? ~b_src : b_src;
            carry  <= sub_eff;
            cnt    <= '0;
            acc_op <= acc_mode;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_nx;
          carry  <= c_d;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            sum_q  <= res_nx;
            cout_q <= c_d;
            if (acc_op) acc <= res_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
